iommu_reg_access: RTL and testbench

- Register-bus front-end that sits directly upstream of the IOMMU register fields.
- Accepts 32-bit bus requests and decodes them onto a bank of NUM_REGS 64-bit registers.
- Produces per-register one-cycle SW write-enable and write-data (we/wd), plus read pulses (re) for read-to-clear fields.
- Returns read data and an error flag through a valid/ready response channel.

---
 rtl/iommu_reg_access_if.sv | 31 +++
 rtl/iommu_reg_access.sv | 160 ++++++++++++++++
 tb/tb_iommu_reg_access.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/iommu_reg_access_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : iommu_reg_access_if
// Brief    : valid/ready request + response channel feeding iommu_reg_access
// Revision : 1.0
// ---------------------------------------------------------------------------
interface iommu_reg_access_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface
`default_nettype wire

// File: rtl/iommu_reg_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : iommu_reg_access
// Brief    : 32-bit bus front-end onto NUM_REGS 64-bit IOMMU registers (we/re/wd).
//            Optional IOMMU_REG_ATOMIC64_EN buffers the low half until the high half.
// Revision : 1.0
// ---------------------------------------------------------------------------
module iommu_reg_access #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  iommu_reg_access_if.slave      bus,
  output logic [NUM_REGS-1:0]    reg_we_o,
  output logic [NUM_REGS-1:0]    reg_re_o,
  output logic [63:0]            reg_wd_o,
  input  logic [NUM_REGS*64-1:0] reg_qs_i
);
  localparam int IDX_W = ADDR_WIDTH - 3;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             write_q, half_q, err_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic [63:0]      qs_arr [NUM_REGS];
  logic [63:0]      cur;
  logic [31:0]      cur_half, merged, low_word;
  logic [63:0]      wd_full;
  logic             commit;

  assign req_idx = bus.req_addr[ADDR_WIDTH-1:3];
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (32'(req_idx) >= 32'(NUM_REGS));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_qs
    assign qs_arr[g] = reg_qs_i[64*g +: 64];
  end

  assign cur      = qs_arr[sel_q];
  assign cur_half = half_q ? cur[63:32] : cur[31:0];

  always_comb begin
    merged = cur_half;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

`ifdef IOMMU_REG_ATOMIC64_EN
  logic             shd_valid_q, shd_valid_d;
  logic [SEL_W-1:0] shd_idx_q, shd_idx_d;
  logic [31:0]      shd_low_q, shd_low_d;

  // Low-half writes park in the shadow; the high-half write commits both words.
  assign low_word = (shd_valid_q && (shd_idx_q == sel_q)) ? shd_low_q : cur[31:0];
  assign commit   = half_q;

  always_comb begin
    shd_valid_d = shd_valid_q;
    shd_idx_d   = shd_idx_q;
    shd_low_d   = shd_low_q;
    if (state_q == EXEC && write_q && !err_q) begin
      if (!half_q) begin
        shd_valid_d = 1'b1;
        shd_idx_d   = sel_q;
        shd_low_d   = merged;
      end else begin
        shd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shd_valid_q <= 1'b0;
      shd_idx_q   <= '0;
      shd_low_q   <= '0;
    end else begin
      shd_valid_q <= shd_valid_d;
      shd_idx_q   <= shd_idx_d;
      shd_low_q   <= shd_low_d;
    end
  end
`else
  assign low_word = cur[31:0];
  assign commit   = 1'b1;
`endif

  assign wd_full = half_q ? {merged, low_word} : {cur[63:32], merged};

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    reg_we_o = '0;
    reg_re_o = '0;
    reg_wd_o = '0;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = EXEC;
      EXEC: begin
        state_d = RESP;
        rdata_d = '0;
        if (!err_q) begin
          if (write_q) begin
            if (commit) begin
              reg_we_o[sel_q] = 1'b1;
              reg_wd_o        = wd_full;
            end
          end else begin
            reg_re_o[sel_q] = 1'b1;
            rdata_d         = cur_half;
          end
        end
      end
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      half_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (state_q == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        half_q  <= bus.req_addr[2];
        err_q   <= req_err;
        sel_q   <= req_idx[SEL_W-1:0];
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  assign bus.rsp_error = (state_q == RESP) && err_q;
endmodule
`default_nettype wire

// File: tb/tb_iommu_reg_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_iommu_reg_access
// Brief    : directed + random requests checked against a register-bank model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_iommu_reg_access;
  localparam int NUM_REGS = 8;
  localparam int AW       = 12;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REGS-1:0]    reg_we, reg_re;
  logic [63:0]            reg_wd;
  logic [NUM_REGS*64-1:0] reg_qs;

  iommu_reg_access_if #(.ADDR_WIDTH(AW)) bus ();

  iommu_reg_access #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(AW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .bus      (bus),
    .reg_we_o (reg_we),
    .reg_re_o (reg_re),
    .reg_wd_o (reg_wd),
    .reg_qs_i (reg_qs)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] qs_m [NUM_REGS];
  bit          sh_v;
  int          sh_idx;
  logic [31:0] sh_lo;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_qs();
    for (int i = 0; i < NUM_REGS; i++) reg_qs[64*i +: 64] = qs_m[i];
  endtask

  task automatic rand_qs();
    for (int i = 0; i < NUM_REGS; i++) qs_m[i] = {$urandom, $urandom};
    set_qs();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_rvalid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({tag, "_rerr"}, 64'(bus.rsp_error), 64'd0);
    check({tag, "_we"}, 64'(reg_we), 64'd0);
    check({tag, "_re"}, 64'(reg_re), 64'd0);
    check({tag, "_wd"}, reg_wd, 64'd0);
  endtask

  // One full transaction; the model predicts we/re/wd and the response.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int hold);
    int                  idx;
    bit                  half, err;
    logic [NUM_REGS-1:0] e_we, e_re;
    logic [63:0]         e_wd, m;
    logic [31:0]         e_rd;
    idx  = int'(addr >> 3);
    half = addr[2];
    err  = (addr[1:0] != 2'b00) || (idx >= NUM_REGS);
    e_we = '0; e_re = '0; e_wd = '0; e_rd = '0;
    if (!err) begin
      if (wr) begin
        m = qs_m[idx];
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m[32*int'(half) + 8*b +: 8] = wdata[8*b +: 8];
`ifdef IOMMU_REG_ATOMIC64_EN
        if (!half) begin
          sh_v = 1'b1; sh_idx = idx; sh_lo = m[31:0];
        end else begin
          if (sh_v && sh_idx == idx) m[31:0] = sh_lo;
          sh_v = 1'b0;
          e_we[idx] = 1'b1; e_wd = m;
        end
`else
        e_we[idx] = 1'b1; e_wd = m;
`endif
      end else begin
        e_re[idx] = 1'b1;
        e_rd = half ? qs_m[idx][63:32] : qs_m[idx][31:0];
      end
    end

    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wstrb = wstrb;
    check("acc_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("exec_we", 64'(reg_we), 64'(e_we));
    check("exec_re", 64'(reg_re), 64'(e_re));
    check("exec_wd", reg_wd, e_wd);
    check("exec_ready", 64'(bus.req_ready), 64'd0);
    check("exec_rvalid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("resp_valid", 64'(bus.rsp_valid), 64'd1);
    check("resp_rdata", 64'(bus.rsp_rdata), 64'(e_rd));
    check("resp_err", 64'(bus.rsp_error), 64'(err));
    check("resp_we", 64'(reg_we | reg_re), 64'd0);
    for (int k = 0; k < hold; k++) begin
      rand_qs();
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rdata", 64'(bus.rsp_rdata), 64'(e_rd));
      check("hold_err", 64'(bus.rsp_error), 64'(err));
      check("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("done_valid", 64'(bus.rsp_valid), 64'd0);
    check("done_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [AW-1:0] a;
    int            r;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.rsp_ready = 1'b0;
    sh_v = 1'b0; sh_idx = 0; sh_lo = '0;
    rand_qs();
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    qs_m[2] = 64'h1122334455667788; set_qs();
    do_txn(1'b0, 12'h010, 32'h0, 4'h0, 0);
    do_txn(1'b1, 12'h014, 32'hAABBCCDD, 4'b0101, 0);
    do_txn(1'b0, 12'h042, 32'h0, 4'h0, 0);
    do_txn(1'b0, 12'h040, 32'h0, 4'h0, 1);
    do_txn(1'b1, 12'h040, 32'h12345678, 4'hF, 0);
    do_txn(1'b0, 12'h01C, 32'h0, 4'h0, 5);
    do_txn(1'b1, 12'h008, 32'h55AA55AA, 4'h0, 2);
    do_txn(1'b1, 12'h000, 32'hDEADBEEF, 4'hF, 0);
    do_txn(1'b1, 12'h004, 32'hCAFEF00D, 4'hF, 0);

    // Reset asserted while a write sits in EXEC.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 12'h014;
    bus.req_wdata = 32'hFFFFFFFF; bus.req_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_exec");
    rst_n = 1'b1;
    sh_v  = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_after");

    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = AW'({$urandom_range(0, 511), 1'b0, 2'($urandom_range(1, 3))});
      else if (r == 1) a = AW'({$urandom_range(8, 511), 1'($urandom_range(0, 1)), 2'b00});
      else             a = AW'({$urandom_range(0, 3), 1'($urandom_range(0, 1)), 2'b00});
      if ($urandom_range(0, 3) == 0) rand_qs();
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
